// File: rtl/montgomery_exp_if.sv
// montgomery_exp_if: start/done link between exponent sequencer and core.
// master = sequencer (issues operands), slave = Montgomery multiplier core.
interface montgomery_exp_if #(
  parameter int N = 1024
);
  logic         mult_start;
  logic [N-1:0] mult_a;
  logic [N-1:0] mult_b;
  logic [N-1:0] mult_m;
  logic [N:0]   mult_result;
  logic         mult_done;

  modport master (
    output mult_start,
    output mult_a,
    output mult_b,
    output mult_m,
    input  mult_result,
    input  mult_done
  );

  modport slave (
    input  mult_start,
    input  mult_a,
    input  mult_b,
    input  mult_m,
    output mult_result,
    output mult_done
  );
endinterface

// File: rtl/montgomery_exp.sv
// montgomery_exp: x^e mod m via MSB-first square-and-always-test MontMuls.
// Ports: clk/resetn, start/in_*, done/err/result, mult_if; MONTEXP_TIMEOUT_EN.
module montgomery_exp #(
  parameter int N       = 1024,
  parameter int E_BITS  = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [N-1:0]        in_x,
  input  logic [E_BITS-1:0]   in_e,
  input  logic [N-1:0]        in_m,
  input  logic [N-1:0]        in_r,
  input  logic [N-1:0]        in_r2,
  output logic                done,
  output logic                err,
  output logic [N-1:0]        result,
  montgomery_exp_if.master    mult_if
);

  localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SQR,
    MUL,
    POST
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [E_BITS-1:0] e_q, e_d;
  logic [N-1:0]      xt_q, xt_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      m_q, m_d;
  logic [N-1:0]      res_q, res_d;
  logic [N-1:0]      opa_q, opa_d;
  logic [N-1:0]      opb_q, opb_d;
  logic              done_q, done_d;
  logic              go_q, go_d;

  logic              ack;
  logic              adv;
  logic [N-1:0]      prod;
  logic              unused_hi;

`ifdef MONTEXP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // core guarantees product < M, so the top bit carries nothing
  assign prod      = mult_if.mult_result[N-1:0];
  assign unused_hi = mult_if.mult_result[N];

  // done is ignored while mult_start is high (stale level)
  assign ack = (state_q != IDLE) && !go_q
             && mult_if.mult_done;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    e_d     = e_q;
    xt_d    = xt_q;
    a_d     = a_q;
    m_d     = m_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    done_d  = 1'b0;
    go_d    = 1'b0;
    adv     = 1'b0;
`ifdef MONTEXP_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif

    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = PRE;
          i_d     = IW'(E_BITS - 1);
          e_d     = in_e;
          m_d     = in_m;
          a_d     = in_r;
          go_d    = 1'b1;
          opa_d   = in_x;
          opb_d   = in_r2;
        end
      end
      (state_q == PRE): begin
        if (ack) begin
          xt_d    = prod;
          state_d = SQR;
          go_d    = 1'b1;
          opa_d   = a_q;
          opb_d   = a_q;
        end
      end
      (state_q == SQR): begin
        if (ack) begin
          a_d = prod;
          if (e_q[E_BITS-1]) begin
            state_d = MUL;
            go_d    = 1'b1;
            opa_d   = prod;
            opb_d   = xt_q;
          end else begin
            adv = 1'b1;
          end
        end
      end
      (state_q == MUL): begin
        if (ack) begin
          a_d = prod;
          adv = 1'b1;
        end
      end
      (state_q == POST): begin
        if (ack) begin
          res_d   = prod;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // zero-cycle NEXT step folded into the SQR/MUL completion
    if (adv) begin
      go_d  = 1'b1;
      e_d   = e_q << 1;
      opa_d = prod;
      if (i_q == '0) begin
        state_d = POST;
        opb_d   = N'(1);
      end else begin
        i_d     = i_q - 1'b1;
        state_d = SQR;
        opb_d   = prod;
      end
    end

`ifdef MONTEXP_TIMEOUT_EN
    if (go_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((state_q != IDLE) && !go_q
        && !mult_if.mult_done
        && (cnt_d == CW'(TIMEOUT))) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
      res_d   = '0;
      go_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      i_q     <= '0;
      e_q     <= '0;
      xt_q    <= '0;
      a_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
`ifdef MONTEXP_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      e_q     <= e_d;
      xt_q    <= xt_d;
      a_q     <= a_d;
      m_q     <= m_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      done_q  <= done_d;
      go_q    <= go_d;
`ifdef MONTEXP_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign done               = done_q;
  assign result             = res_q;
  assign mult_if.mult_start = go_q;
  assign mult_if.mult_a     = opa_q;
  assign mult_if.mult_b     = opb_q;
  assign mult_if.mult_m     = m_q;

`ifdef MONTEXP_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_montgomery_exp.sv
// tb_montgomery_exp: directed checks of montgomery_exp, small and 1024-bit.
// Behavioural cores answer each mult_start three cycles later.
module tb_montgomery_exp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- small instance: N=8, E_BITS=4 ----------------
  logic       s_start = 1'b0;
  logic [7:0] s_x = 8'd5;
  logic [3:0] s_e = 4'd0;
  logic [7:0] s_m = 8'd13;
  logic [7:0] s_r = 8'd9;
  logic [7:0] s_r2 = 8'd3;
  logic       s_done;
  logic       s_err;
  logic [7:0] s_result;

  montgomery_exp_if #(.N(8)) s_if ();

  montgomery_exp #(
    .N(8),
    .E_BITS(4),
    .TIMEOUT(16)
  ) u_small (
    .clk(clk),
    .resetn(resetn),
    .start(s_start),
    .in_x(s_x),
    .in_e(s_e),
    .in_m(s_m),
    .in_r(s_r),
    .in_r2(s_r2),
    .done(s_done),
    .err(s_err),
    .result(s_result),
    .mult_if(s_if.master)
  );

  // ---------------- big instance: N=1024, E_BITS=17 ----------------
  logic          b_start = 1'b0;
  logic [1023:0] b_x = '0;
  logic [16:0]   b_e = '0;
  logic [1023:0] b_m = '0;
  logic [1023:0] b_r = '0;
  logic [1023:0] b_r2 = '0;
  logic          b_done;
  logic          b_err;
  logic [1023:0] b_result;

  montgomery_exp_if #(.N(1024)) b_if ();

  montgomery_exp #(
    .N(1024),
    .E_BITS(17),
    .TIMEOUT(4096)
  ) u_big (
    .clk(clk),
    .resetn(resetn),
    .start(b_start),
    .in_x(b_x),
    .in_e(b_e),
    .in_m(b_m),
    .in_r(b_r),
    .in_r2(b_r2),
    .done(b_done),
    .err(b_err),
    .result(b_result),
    .mult_if(b_if.master)
  );

  // Montgomery product a*b*2^-n mod m, bit-serial REDC
  function automatic logic [1025:0] redc(
    input logic [1023:0] a,
    input logic [1023:0] b,
    input logic [1023:0] m,
    input int n
  );
    logic [1025:0] t;
    t = '0;
    for (int i = 0; i < n; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t;
  endfunction

  function automatic logic [1023:0] modpow(
    input logic [1023:0] x,
    input logic [1023:0] m,
    input logic [16:0]   e
  );
    logic [2047:0] acc;
    logic [2047:0] mm;
    logic [2047:0] xx;
    acc = '0;
    acc[0] = 1'b1;
    mm = {1024'b0, m};
    xx = {1024'b0, x};
    for (int i = 16; i >= 0; i--) begin
      acc = (acc * acc) % mm;
      if (e[i]) acc = (acc * xx) % mm;
    end
    return acc[1023:0];
  endfunction

  // ---------------- behavioural cores, L = 3 ----------------
  logic       s_pend = 1'b0;
  int         s_cnt = 0;
  logic [8:0] s_cres = '0;
  logic       s_hang = 1'b0;
  logic [1025:0] s_tmp;

  always @(posedge clk) begin
    if (s_if.mult_start) begin
      s_tmp = redc({1016'b0, s_if.mult_a},
                   {1016'b0, s_if.mult_b},
                   {1016'b0, s_if.mult_m}, 8);
      s_pend <= 1'b1;
      s_cnt  <= 1;
      s_cres <= s_tmp[8:0];
    end else if (s_pend) begin
      if (s_cnt == 3) s_pend <= 1'b0;
      else s_cnt <= s_cnt + 1;
    end
  end

  assign s_if.mult_done   = s_pend && (s_cnt == 3) && !s_hang;
  assign s_if.mult_result = s_cres;

  logic          b_pend = 1'b0;
  int            b_cnt = 0;
  logic [1024:0] b_cres = '0;
  logic [1025:0] b_tmp;

  always @(posedge clk) begin
    if (b_if.mult_start) begin
      b_tmp = redc(b_if.mult_a, b_if.mult_b,
                   b_if.mult_m, 1024);
      b_pend <= 1'b1;
      b_cnt  <= 1;
      b_cres <= b_tmp[1024:0];
    end else if (b_pend) begin
      if (b_cnt == 3) b_pend <= 1'b0;
      else b_cnt <= b_cnt + 1;
    end
  end

  assign b_if.mult_done   = b_pend && (b_cnt == 3);
  assign b_if.mult_result = b_cres;

  // ---------------- monitors ----------------
  int s_starts = 0;
  int s_dones = 0;
  int b_starts = 0;

  always @(posedge clk) begin
    if (s_if.mult_start) s_starts++;
    if (s_done) s_dones++;
    if (b_if.mult_start) b_starts++;
  end

  // ---------------- checks ----------------
  task automatic chkv(input string tag,
                      input logic [1023:0] obs,
                      input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag,
                      input int obs,
                      input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic s_go(input logic [3:0] e);
    s_e = e;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic s_wait(input string tag,
                        input int budget,
                        output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      if (s_done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chki(tag, int'(at >= 0), 1);
  endtask

  task automatic s_rst_out(input string tag);
    chkv({tag, "_done"}, {1023'b0, s_done}, '0);
    chkv({tag, "_err"}, {1023'b0, s_err}, '0);
    chkv({tag, "_res"}, {1016'b0, s_result}, '0);
    chkv({tag, "_ms"}, {1023'b0, s_if.mult_start}, '0);
    chkv({tag, "_ma"}, {1016'b0, s_if.mult_a}, '0);
    chkv({tag, "_mb"}, {1016'b0, s_if.mult_b}, '0);
    chkv({tag, "_mm"}, {1016'b0, s_if.mult_m}, '0);
  endtask

  int st0;
  int dn0;
  int at;
  int f;
  int ndone;
  logic [1024:0] rb;
  logic [2047:0] rr;

  initial begin
    // reset
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    s_rst_out("rst");
    resetn = 1'b1;

    // e=3: 5^3 mod 13 = 8, 2+4+2 = 8 multiplies
    st0 = s_starts;
    dn0 = s_dones;
    s_go(4'd3);
    chki("t1_issue", int'(s_if.mult_start), 1);
    chkv("t1_pre_a", {1016'b0, s_if.mult_a}, 1024'd5);
    chkv("t1_pre_b", {1016'b0, s_if.mult_b}, 1024'd3);
    chkv("t1_m", {1016'b0, s_if.mult_m}, 1024'd13);
    @(negedge clk);
    chki("t1_one_pulse", int'(s_if.mult_start), 0);
    repeat (3) @(negedge clk);
    chki("t1_sqr_issue", int'(s_if.mult_start), 1);
    chkv("t1_sqr_a", {1016'b0, s_if.mult_a}, 1024'd9);
    chkv("t1_sqr_b", {1016'b0, s_if.mult_b}, 1024'd9);
    s_wait("t1_done_seen", 200, at);
    chkv("t1_result", {1016'b0, s_result}, 1024'd8);
    chki("t1_err", int'(s_err), 0);
    @(negedge clk);
    chki("t1_done_width", int'(s_done), 0);
    chki("t1_starts", s_starts - st0, 8);
    chki("t1_dones", s_dones - dn0, 1);

    // e=0: result 1, 6 multiplies
    st0 = s_starts;
    s_go(4'd0);
    s_wait("t2_done_seen", 200, at);
    chkv("t2_result", {1016'b0, s_result}, 1024'd1);
    @(negedge clk);
    chki("t2_starts", s_starts - st0, 6);

    // start re-asserted during WAIT is ignored
    st0 = s_starts;
    s_go(4'd3);
    @(negedge clk);
    s_e = 4'd0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_wait("t3_done_seen", 200, at);
    chkv("t3_result", {1016'b0, s_result}, 1024'd8);
    @(negedge clk);
    chki("t3_starts", s_starts - st0, 8);

    // reset in the middle of the first SQR wait
    s_go(4'd3);
    repeat (4) @(negedge clk);
    chki("t4_sqr_issue", int'(s_if.mult_start), 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    s_rst_out("t4_rst");
    st0 = s_starts;
    dn0 = s_dones;
    repeat (8) @(negedge clk);
    chki("t4_late_starts", s_starts - st0, 0);
    chki("t4_late_dones", s_dones - dn0, 0);
    st0 = s_starts;
    s_go(4'd3);
    s_wait("t4_done_seen", 200, at);
    chkv("t4_result", {1016'b0, s_result}, 1024'd8);
    @(negedge clk);
    chki("t4_starts", s_starts - st0, 8);

    // core that never answers
    s_hang = 1'b1;
    s_go(4'd3);
    f = cyc;
    chki("t5_issue", int'(s_if.mult_start), 1);
`ifdef MONTEXP_TIMEOUT_EN
    s_wait("t5_done_seen", 60, at);
    chki("t5_latency", at - f, 17);
    chki("t5_err", int'(s_err), 1);
    chkv("t5_result", {1016'b0, s_result}, '0);
`else
    ndone = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (s_done) ndone++;
    end
    chki("t5_no_done", ndone, 0);
`endif
    s_hang = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // N=1024, E_BITS=17, e=65537
    for (int w = 0; w < 32; w++) begin
      b_m[w*32 +: 32] = $urandom;
      b_x[w*32 +: 32] = $urandom;
    end
    b_m[1023] = 1'b1;
    b_m[0]    = 1'b1;
    b_x[1023] = 1'b0;
    rb = '0;
    rb[1024] = 1'b1;
    rb = rb % {1'b0, b_m};
    b_r = rb[1023:0];
    rr = ({1024'b0, b_r} * {1024'b0, b_r})
       % {1024'b0, b_m};
    b_r2 = rr[1023:0];
    b_e = 17'd65537;
    st0 = b_starts;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    at = -1;
    for (int k = 0; k < 400; k++) begin
      if (b_done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chki("t6_done_seen", int'(at >= 0), 1);
    chkv("t6_result", b_result, modpow(b_x, b_m, b_e));
    chki("t6_err", int'(b_err), 0);
    @(negedge clk);
    chki("t6_starts", b_starts - st0, 21);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
